fetch_inst_queue: RTL

//  - Decoupling FIFO directly downstream of the frontend ibuffer port; feeds the decode stage.
//  - Buffers one fetched instruction per entry: {inst, pc, predicttaken, predicttarget} (129 b).
//  - Produces the ready back to the frontend (the frontend stalls when ready is low).
//  - Discards all queued instructions on a redirect flush.

---
 rtl/fetch_inst_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO with flush.
// Define FETCHQ_BYPASS_EN for a 0-cycle empty-queue bypass path.
module fetch_inst_queue #(
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [63:0]      in_pc,
   input  logic             in_predicttaken,
   input  logic [31:0]      in_predicttarget,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [63:0]      out_pc,
   output logic             out_predicttaken,
   output logic [31:0]      out_predicttarget,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           in_e;
   entry_t           out_e;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             stored_valid;
   logic             byp;
   logic             enq;
   logic             deq;

   assign in_e = '{
      inst:   in_inst,
      pc:     in_pc,
      taken:  in_predicttaken,
      target: in_predicttarget
   };

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;

   assign stored_valid = !empty && !flush;

`ifdef FETCHQ_BYPASS_EN
   assign byp = empty && in_valid && !flush;
`else
   assign byp = 1'b0;
`endif

   assign out_valid = stored_valid || byp;

   // A bypassed instruction taken by decode never touches storage.
   assign enq = in_valid && in_ready && !flush && !(byp && out_ready);
   assign deq = stored_valid && out_ready;

   always_comb begin
      out_e = '0;
      if (byp)
         out_e = in_e;
      else if (stored_valid)
         out_e = mem[rd_ptr];
   end

   assign out_inst          = out_e.inst;
   assign out_pc            = out_e.pc;
   assign out_predicttaken  = out_e.taken;
   assign out_predicttarget = out_e.target;

   always_ff @(posedge clock) begin
      if (enq)
         mem[wr_ptr] <= in_e;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   a_count_range: assert property (
      @(posedge clock) disable iff (!reset_n)
      count <= CNT_W'(DEPTH));

   a_no_enq_full: assert property (
      @(posedge clock) disable iff (!reset_n)
      full |-> !enq);

endmodule
